// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared types and helpers for the shared game countdown timer.
package game_timer_pkg;

  localparam int NUM_REQ  = 3;
  localparam int REQ_EASY = 0;
  localparam int REQ_MED  = 1;
  localparam int REQ_HARD = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_EXPIRE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Binary 1..99 to two BCD digits; only ever called on elaboration-time constants.
  function automatic bcd2_t to_bcd2(input int unsigned val);
    bcd2_t r;
    r.tens = 4'((val / 10) % 10);
    r.ones = 4'(val % 10);
    return r;
  endfunction

endpackage

// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: request/restart inputs and grant/timeout/display outputs
// between the difficulty controllers (master) and the shared timer (slave).
interface timer_arbiter_if;
  import game_timer_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] restart;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] timeout;
  logic [3:0]         ones;
  logic [3:0]         tens;
  logic               busy;
  logic               warn;

  modport master (
    output req, restart,
    input  grant, timeout, ones, tens, busy, warn
  );

  modport slave (
    input  req, restart,
    output grant, timeout, ones, tens, busy, warn
  );

endinterface

// File: rtl/bcd_down_counter2.sv
// bcd_down_counter2: two-digit BCD down counter with synchronous load,
// decrement enable (saturating at 00) and a zero flag.
module bcd_down_counter2
  import game_timer_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  bcd2_t load_val_i,
  input  logic  dec_i,
  output bcd2_t cnt_o,
  output bcd2_t cnt_next_o,
  output logic  zero_o
);

  bcd2_t cnt_q, cnt_d;

  assign zero_o     = (cnt_q == '0);
  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

  // Load has priority; a decrement borrows from tens when ones is 0.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      if (cnt_q.ones == 4'd0) begin
        cnt_d.ones = 4'd9;
        cnt_d.tens = cnt_q.tens - 4'd1;
      end else begin
        cnt_d.ones = cnt_q.ones - 4'd1;
      end
    end
  end

  // Count register, cleared to 00 on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin owner of one shared seconds countdown for the
// easy/medium/hard game controllers. Optional build macro LOW_TIME_WARN_EN
// drives warn while running with a low count; otherwise warn is tied low.
//
// state  | meaning
// IDLE   | no owner; arbitrate on req
// RUN    | owner granted, counting down
// EXPIRE | count hit 00; one-cycle timeout pulse to owner
// HOLD   | expired, grant held until owner drops req
module timer_arbiter
  import game_timer_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int SECS0     = 10,
  parameter int SECS1     = 12,
  parameter int SECS2     = 12,
  parameter int WARN_SECS = 3
) (
  input  logic           clk,
  input  logic           rst,
  timer_arbiter_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] timeout_q, timeout_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               busy_q, busy_d;
  logic               warn_q, warn_d;

  logic               pick_vld;
  logic [1:0]         pick_idx, pick_cand;
  logic               own_req, own_rst, tick;
  logic               cnt_load, cnt_dec, cnt_zero;
  bcd2_t              cnt_val, cnt_next, load_val;

  // While a grant is held the pointer equals the owner index.
  function automatic bcd2_t reload_bcd(input logic [1:0] idx);
    bcd2_t r;
    case (idx)
      2'(REQ_EASY): r = to_bcd2(SECS0);
      2'(REQ_MED):  r = to_bcd2(SECS1);
      2'(REQ_HARD): r = to_bcd2(SECS2);
      default:      r = to_bcd2(SECS0);
    endcase
    return r;
  endfunction

  assign own_req = |(bus.req & grant_q);
  assign own_rst = |(bus.restart & grant_q);
  assign tick    = (presc_q == PW'(TICK_DIV - 1));

  // Round-robin pick: first asserted request searching from pointer+1.
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pick_cand = 2'((int'(ptr_q) + k) % NUM_REQ);
      if (!pick_vld && bus.req[pick_cand]) begin
        pick_vld = 1'b1;
        pick_idx = pick_cand;
      end
    end
  end

  // Next-state: release beats restart, restart beats the final tick.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    timeout_d = '0;
    ptr_d     = ptr_q;
    presc_d   = presc_q;
    busy_d    = busy_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    load_val  = reload_bcd(ptr_q);
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d  = ST_RUN;
          grant_d  = NUM_REQ'(1) << pick_idx;
          ptr_d    = pick_idx;
          busy_d   = 1'b1;
          presc_d  = '0;
          cnt_load = 1'b1;
          load_val = reload_bcd(pick_idx);
        end
      end
      ST_RUN, ST_HOLD: begin
        if (!own_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (own_rst) begin
          state_d  = ST_RUN;
          presc_d  = '0;
          cnt_load = 1'b1;
        end else if (state_q == ST_RUN) begin
          if (tick) begin
            presc_d = '0;
            cnt_dec = 1'b1;
            if (cnt_val.tens == 4'd0 && cnt_val.ones == 4'd1) begin
              state_d   = ST_EXPIRE;
              timeout_d = grant_q;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      ST_EXPIRE: begin
        if (!own_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef LOW_TIME_WARN_EN
  assign warn_d = (state_d == ST_RUN) &&
                  ((int'(cnt_next.tens) * 10 + int'(cnt_next.ones)) <= WARN_SECS);
`else
  localparam int unused_warn_secs = WARN_SECS;
  logic unused_next;
  assign unused_next = ^cnt_next;
  assign warn_d      = 1'b0;
`endif

  bcd_down_counter2 u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (load_val),
    .dec_i      (cnt_dec & ~cnt_zero),
    .cnt_o      (cnt_val),
    .cnt_next_o (cnt_next),
    .zero_o     (cnt_zero)
  );

  // Control registers; pointer resets to 2 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      timeout_q <= '0;
      ptr_q     <= 2'(REQ_HARD);
      presc_q   <= '0;
      busy_q    <= 1'b0;
      warn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      presc_q   <= presc_d;
      busy_q    <= busy_d;
      warn_q    <= warn_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.timeout = timeout_q;
  assign bus.ones    = cnt_val.ones;
  assign bus.tens    = cnt_val.tens;
  assign bus.busy    = busy_q;
  assign bus.warn    = warn_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: scoreboard bench; the driver steps an integer reference
// model per cycle and queues the expected outputs, the monitor compares.
module tb_timer_arbiter;
  import game_timer_pkg::*;

  localparam int TICK = 4;
  localparam int S0   = 3;
  localparam int S1   = 5;
  localparam int S2   = 12;
  localparam int WARN = 3;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_EXP  = 2;
  localparam int P_HOLD = 3;

  typedef struct packed {
    logic [2:0] grant;
    logic [2:0] timeout;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       warn;
  } obs_t;

  logic clk;
  logic rst;
  timer_arbiter_if bus ();

  timer_arbiter #(
    .TICK_DIV  (TICK),
    .SECS0     (S0),
    .SECS1     (S1),
    .SECS2     (S2),
    .WARN_SECS (WARN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: seconds left, cycles into the current second, owner.
  int m_phase, m_owner, m_ptr, m_secs, m_cyc, m_to;
  logic [2:0] cur_req;

  function automatic int secs_for(input int i);
    if (i == 0) return S0;
    if (i == 1) return S1;
    return S2;
  endfunction

  function automatic void model_reset();
    m_phase = P_IDLE; m_owner = -1; m_ptr = 2; m_secs = 0; m_cyc = 0; m_to = -1;
  endfunction

  function automatic void model_step(input logic [2:0] r, input logic [2:0] rs, input logic rn);
    int pick;
    logic own_r, own_rs;
    m_to = -1;
    if (!rn) begin
      model_reset();
      return;
    end
    own_r  = (m_owner >= 0) ? r[2'(m_owner)]  : 1'b0;
    own_rs = (m_owner >= 0) ? rs[2'(m_owner)] : 1'b0;
    if (m_phase == P_IDLE) begin
      pick = -1;
      for (int k = 1; k <= 3; k++)
        if (pick < 0 && r[2'((m_ptr + k) % 3)]) pick = (m_ptr + k) % 3;
      if (pick >= 0) begin
        m_owner = pick; m_ptr = pick; m_secs = secs_for(pick); m_cyc = 0; m_phase = P_RUN;
      end
    end else if (!own_r) begin
      m_owner = -1; m_phase = P_IDLE;
    end else if (own_rs && (m_phase == P_RUN || m_phase == P_HOLD)) begin
      m_secs = secs_for(m_owner); m_cyc = 0; m_phase = P_RUN;
    end else if (m_phase == P_RUN) begin
      if (m_cyc == TICK - 1) begin
        m_cyc = 0;
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_phase = P_EXP; m_to = m_owner;
        end
      end else begin
        m_cyc = m_cyc + 1;
      end
    end else if (m_phase == P_EXP) begin
      m_phase = P_HOLD;
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.grant   = (m_owner >= 0) ? (3'(1) << m_owner) : 3'b000;
    o.timeout = (m_to >= 0) ? (3'(1) << m_to) : 3'b000;
    o.tens    = 4'(m_secs / 10);
    o.ones    = 4'(m_secs % 10);
    o.busy    = (m_owner >= 0);
`ifdef LOW_TIME_WARN_EN
    o.warn    = (m_phase == P_RUN) && (m_secs <= WARN);
`else
    o.warn    = 1'b0;
`endif
    return o;
  endfunction

  task automatic drive(input logic [2:0] r, input logic [2:0] rs, input logic rn);
    @(negedge clk);
    rst         = rn;
    bus.req     = r;
    bus.restart = rs;
    cur_req     = r;
    model_step(r, rs, rn);
    sb_q.push_back(model_obs());
  endtask

  task automatic run_to_phase(input logic [2:0] r, input int ph);
    for (int i = 0; i < 200 && m_phase != ph; i++) drive(r, 3'b000, 1'b1);
  endtask

  // Runs until the next edge is the 01->00 tick.
  task automatic run_to_final_tick(input logic [2:0] r);
    for (int i = 0; i < 200 && !(m_phase == P_RUN && m_secs == 1 && m_cyc == TICK - 1); i++)
      drive(r, 3'b000, 1'b1);
  endtask

  // Monitor: every cycle the DUT presents registered outputs; compare.
  initial begin
    obs_t act, exp_o;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_o = sb_q.pop_front();
        act = '{grant: bus.grant, timeout: bus.timeout, tens: bus.tens,
                ones: bus.ones, busy: bus.busy, warn: bus.warn};
        checks++;
        if (act !== exp_o) begin
          failures++;
          $display("FAIL outputs t=%0t got g=%b to=%b d=%h%h busy=%b warn=%b want g=%b to=%b d=%h%h busy=%b warn=%b",
                   $time, act.grant, act.timeout, act.tens, act.ones, act.busy, act.warn,
                   exp_o.grant, exp_o.timeout, exp_o.tens, exp_o.ones, exp_o.busy, exp_o.warn);
        end
        checks++;
        if (!$onehot0(act.grant) || ((act.timeout & ~act.grant) != 3'b000)) begin
          failures++;
          $display("FAIL grant_invariant t=%0t got g=%b to=%b want onehot0 grant, timeout within grant",
                   $time, act.grant, act.timeout);
        end
      end
    end
  end

  initial begin
    logic [2:0] r, rs;
    logic       rn;
    rst = 1'b0; bus.req = '0; bus.restart = '0; cur_req = '0;
    model_reset();

    drive(3'b000, 3'b000, 1'b0);
    drive(3'b000, 3'b000, 1'b0);
    drive(3'b000, 3'b000, 1'b1);

    // Easy countdown to expiry and hold, then release.
    for (int i = 0; i < 20; i++) drive(3'b001, 3'b000, 1'b1);
    drive(3'b000, 3'b000, 1'b1);
    drive(3'b000, 3'b000, 1'b1);

    // Round robin from a fresh pointer.
    drive(3'b000, 3'b000, 1'b0);
    drive(3'b000, 3'b000, 1'b1);
    for (int n = 0; n < 4; n++) begin
      run_to_phase(3'b111, P_HOLD);
      drive(3'b111 & ~(3'(1) << m_owner), 3'b000, 1'b1);
    end
    drive(3'b000, 3'b000, 1'b1);

    // Hard: 12 -> 11 -> 10 -> 09 borrow and on to expiry.
    run_to_phase(3'b100, P_HOLD);
    drive(3'b000, 3'b000, 1'b1);

    // Restart on the final tick, then a non-owner restart.
    run_to_final_tick(3'b001);
    drive(3'b001, 3'b001, 1'b1);
    for (int i = 0; i < 3; i++) drive(3'b001, 3'b010, 1'b1);
    run_to_phase(3'b001, P_HOLD);
    drive(3'b001, 3'b001, 1'b1);
    run_to_phase(3'b001, P_EXP);
    drive(3'b001, 3'b001, 1'b1);
    drive(3'b000, 3'b000, 1'b1);

    // Release on the final tick.
    run_to_final_tick(3'b001);
    drive(3'b000, 3'b001, 1'b1);
    drive(3'b000, 3'b000, 1'b1);

    // Reset in the middle of a run, then all request.
    for (int i = 0; i < 6; i++) drive(3'b010, 3'b000, 1'b1);
    drive(3'b010, 3'b000, 1'b0);
    drive(3'b000, 3'b000, 1'b1);
    for (int i = 0; i < 5; i++) drive(3'b111, 3'b000, 1'b1);
    drive(3'b000, 3'b000, 1'b1);

    // Randomized controllers.
    for (int c = 0; c < 3000; c++) begin
      r = cur_req;
      for (int i = 0; i < 3; i++) begin
        if (r[i]) begin
          if (m_owner == i && m_phase == P_HOLD) begin
            if ($urandom_range(0, 3) == 0) r[i] = 1'b0;
          end else if ($urandom_range(0, 39) == 0) begin
            r[i] = 1'b0;
          end
        end else if ($urandom_range(0, 5) == 0) begin
          r[i] = 1'b1;
        end
      end
      rs = '0;
      for (int i = 0; i < 3; i++) rs[i] = ($urandom_range(0, 11) == 0);
      rn = ($urandom_range(0, 499) != 0);
      drive(r, rs, rn);
    end
    drive(3'b000, 3'b000, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d pending want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one seconds-countdown timer between the three difficulty game controllers (requester 0 = easy, 1 = medium, 2 = hard); replaces the per-difficulty timer instances.
- Arbitrates round-robin and configures the reload value for the granted requester.
- Sequences countdown, expiry and release, and drives the BCD seconds digits to the 7-segment path.

Parameters:
- TICK_DIV, 50000000: clk cycles per 1-second tick; legal range 2..2^26.
- SECS0, 10: easy reload, seconds; legal range 1..99.
- SECS1, 12: medium reload, seconds; legal range 1..99.
- SECS2, 12: hard reload, seconds; legal range 1..99.
- WARN_SECS, 3: low-time warning threshold, seconds; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- req  in  3  per-requester timer request; level; held for the whole use.
- restart  in  3  per-requester reload pulse; honoured only from the current owner.
- grant  out  3  one-hot owner; zero when idle.
- timeout  out  3  one-cycle expiry pulse to the owner.
- ones  out  4  BCD seconds, ones digit.
- tens  out  4  BCD seconds, tens digit.
- busy  out  1  timer owned; high whenever grant is nonzero.
- warn  out  1  low-time flag.

Behaviour:
- All outputs are registered.
- Reset (rst=0, any state) forces:
  - IDLE state.
  - grant=0, timeout=0, ones=0, tens=0, busy=0, warn=0.
  - Prescaler=0 and RR pointer=2, so requester 0 has first priority.
- States: IDLE, RUN, EXPIRE, HOLD.
- IDLE:
  - Sample req; if nonzero, pick the first asserted index searching from pointer+1 mod 3.
  - Next cycle: grant one-hot asserted, busy=1, digits loaded with SECSi in BCD, prescaler=0, state RUN.
  - Latency from req rise to grant is 1 cycle.
  - The pointer updates to the granted index.
- RUN:
  - Prescaler counts 0..TICK_DIV-1.
  - On a wrap, the BCD count decrements: ones borrows from tens, and ones 0 becomes 9.
  - If the count was 01, the decrement produces 00 and the next state is EXPIRE.
- EXPIRE: one cycle; timeout[owner]=1 with digits at 00; next state HOLD.
- HOLD: grant held, digits stay 00, no further timeout pulses.
- Release:
  - If req[owner]=0 in RUN, EXPIRE or HOLD, the next cycle gives grant=0, busy=0, state IDLE, digits frozen at their last value.
  - The timer is not re-granted in the same cycle as release; IDLE takes at least 1 cycle.
- restart[owner]=1 in RUN or HOLD: reload SECSi, clear the prescaler, go to RUN.
  - restart from a non-owner, or in IDLE, is ignored.
- Simultaneous events:
  - restart and the 01→00 tick in the same cycle: restart wins; no timeout.
  - req[owner] drop and the final tick in the same cycle: release wins; no timeout.
  - req drop and restart together: release wins.
- Non-owner req assertions never preempt; they wait for release.
- grant is always one-hot or zero; timeout is a subset of grant.

Optional Feature:
- Macro: LOW_TIME_WARN_EN.
- Defined: warn=1 while state is RUN and the BCD count is ≤ WARN_SECS; warn=0 elsewhere.
- Undefined: warn tied 0; the port remains.

Decomposition:
- Package game_timer_pkg contains:
  - The state enum (IDLE/RUN/EXPIRE/HOLD).
  - Requester index constants REQ_EASY=0, REQ_MED=1, REQ_HARD=2.
  - The NUM_REQ=3 constant.
  - A 2-digit BCD struct type.
  - A function converting 1..99 to BCD.
- One sub-module, bcd_down_counter2: synchronous load, decrement enable, zero flag.
- Arbitration and FSM stay in the top level.

Test Plan (TICK_DIV=4, SECS0=3, SECS1=5, SECS2=12):
- Reset: rst=0 mid-RUN → next edge shows grant=0, busy=0, digits 0; after release, req=3'b111 grants index 0 first.
- Easy countdown: req=001 → grant=001 after 1 cycle, digits 03; they decrement every 4 cycles through 02, 01, 00. The 00 cycle is EXPIRE with timeout=001 for exactly 1 cycle, then HOLD until req drops.
- Round-robin: req=111 held, each owner drops req after expiry then re-asserts → grants in sequence 001, 010, 100, 001.
- Hard BCD borrow: grant index 2 → digits 12 → 11 → 10 → 09 (tens 0, ones 9), with no skipped or illegal codes.
- Restart races:
  - restart[0] on the same cycle as the 01→00 tick → digits 03, no timeout.
  - restart[1] while index 0 owns → ignored.
- Release race: drop req[owner] on the final-tick cycle → grant=0 next cycle, timeout never asserts. With LOW_TIME_WARN_EN, warn=1 at 03..01 in RUN and 0 in HOLD.
